// File: rtl/lfsr_stimulus_bank.sv
// Multi-channel pseudo-random stimulus source. Each channel owns a 32-bit
// Galois LFSR; the bank also folds DUT outputs into a rotate-XOR signature
// and exposes a single registered parity bit so the DUT logic stays live.
module lfsr_stimulus_bank #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] SEED_BASE = 32'd3,
  parameter logic [31:0] SEED_STEP = 32'd2,
  parameter int unsigned SIG_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      step,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH*WIDTH-1:0]   stim_out,
  output logic [31:0]               adv_count,
  input  logic [SIG_WIDTH-1:0]      sig_in,
  output logic                      sig_out
);

  // x^32 + x^22 + x^2 + x + 1, maximal length
  localparam logic [31:0] Poly = 32'h80200003;

  typedef enum logic [1:0] {
    ModeFree   = 2'b00,
    ModeStep   = 2'b01,
    ModeHold   = 2'b10,
    ModeReload = 2'b11
  } mode_e;

  // A computed seed of zero would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] chan_seed(input int unsigned idx);
    logic [31:0] s;
    s = SEED_BASE + SEED_STEP * idx;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? Poly : 32'd0);
  endfunction

  mode_e mode_sel;
  logic  adv;
  logic  reload;

  assign mode_sel = mode_e'(mode);
  assign reload   = (mode_sel == ModeReload);
  // Hold mode falls out naturally: neither reload nor adv can be true.
  assign adv      = en && ((mode_sel == ModeFree) || ((mode_sel == ModeStep) && step));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next state: reload beats advance; otherwise hold.
    always_comb begin
      state_d = state_q;
      if (reload) begin
        state_d = chan_seed(i);
      end else if (adv && ch_en[i]) begin
        state_d = lfsr_next(state_q);
      end
    end

    // Channel state register, reset to the channel seed.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= chan_seed(i);
      end else begin
        state_q <= state_d;
      end
    end

    assign stim_out[i*WIDTH +: WIDTH] = state_q[WIDTH-1:0];
  end

  logic [31:0] adv_count_q;

  // Counts advance cycles even when every channel is masked off.
  always_ff @(posedge clk) begin
    if (reset) begin
      adv_count_q <= 32'd0;
    end else if (adv) begin
      adv_count_q <= adv_count_q + 32'd1;
    end
  end

  assign adv_count = adv_count_q;

  logic [SIG_WIDTH-1:0] sig_q;
  logic [SIG_WIDTH-1:0] sig_d;
  logic                 sig_out_q;

  // Rotate-left then fold in the DUT outputs.
  always_comb begin
    sig_d = {sig_q[SIG_WIDTH-2:0], sig_q[SIG_WIDTH-1]} ^ sig_in;
  end

  // Signature and its parity run every cycle regardless of en and mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q     <= '0;
      sig_out_q <= 1'b0;
    end else begin
      sig_q     <= sig_d;
      sig_out_q <= ^sig_q;
    end
  end

  assign sig_out = sig_out_q;

endmodule
